// File: rtl/jk_pkg.sv
// Shared command codes, FSM encodings and the expected-Q rule
// for the JK cell command scheduler.
package jk_pkg;

    typedef logic [1:0] jk_cmd_t;

    localparam jk_cmd_t CMD_HOLD = 2'b00;
    localparam jk_cmd_t CMD_RST  = 2'b01;
    localparam jk_cmd_t CMD_SET  = 2'b10;
    localparam jk_cmd_t CMD_TGL  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_APPLY  = 2'b01;
    localparam logic [1:0] ST_VERIFY = 2'b10;

    function automatic logic exp_q(input jk_cmd_t cmd, input logic q_prev);
        logic q;
        case (cmd)
            CMD_HOLD: q = q_prev;
            CMD_RST:  q = 1'b0;
            CMD_SET:  q = 1'b1;
            CMD_TGL:  q = ~q_prev;
            default:  q = q_prev;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Free-running clock-rate divider: one-cycle tick every
// OLD_HZ/NEW_HZ input cycles, constant high when the ratio is 1.
module tick_div #(
    parameter int OLD_HZ = 10,
    parameter int NEW_HZ = 1
) (
    input  logic iClk,
    input  logic iReset,
    output logic oTick
);

    generate
        if (NEW_HZ < 1 || NEW_HZ > OLD_HZ) begin : g_bad_rate
            $error("tick_div: NEW_HZ must be in 1..OLD_HZ");
        end
    endgenerate

    localparam int DIV = (NEW_HZ > 0) ? (OLD_HZ / NEW_HZ) : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge iClk) begin
        if (!iReset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign oTick = (count == LAST);

endmodule

// File: rtl/jk_cmd_sched.sv
// Round-robin scheduler sharing one JK cell between two requesters;
// applies the granted command until a tick, then verifies Q.
module jk_cmd_sched
    import jk_pkg::*;
#(
    parameter int OLD_HZ = 10,
    parameter int NEW_HZ = 1
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic [1:0] iReq,
    input  logic [1:0] iCmd0,
    input  logic [1:0] iCmd1,
    input  logic       iQ,
    output logic       oJ,
    output logic       oK,
    output logic       oTick,
    output logic [1:0] oGnt,
    output logic [1:0] oDone,
    output logic       oErr,
    output logic       oBusy
);

    logic [1:0] state;
    logic [1:0] gnt;
    jk_cmd_t    cmd;
    logic       q_prev;
    logic       rr;
    logic [1:0] win;
    logic       tick;

    tick_div #(
        .OLD_HZ(OLD_HZ),
        .NEW_HZ(NEW_HZ)
    ) u_div (
        .iClk  (iClk),
        .iReset(iReset),
        .oTick (tick)
    );

    // rr == 0 favours requester 0 when both ask at once
    always_comb begin
        win = iReq;
        if (iReq == 2'b11) begin
            win = rr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iReset) begin
            state  <= ST_IDLE;
            gnt    <= 2'b00;
            cmd    <= CMD_HOLD;
            q_prev <= 1'b0;
            rr     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iReq != 2'b00) begin
                        gnt    <= win;
                        cmd    <= win[1] ? iCmd1 : iCmd0;
                        q_prev <= iQ;
                        state  <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (tick) begin
                        state <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    rr    <= gnt[0];
                    gnt   <= 2'b00;
                    state <= ST_IDLE;
                end
                default: begin
                    gnt   <= 2'b00;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oTick = tick;
    assign oGnt  = gnt;
    assign oJ    = (state == ST_APPLY) & cmd[1];
    assign oK    = (state == ST_APPLY) & cmd[0];
    assign oBusy = (state == ST_APPLY) | (state == ST_VERIFY);
    assign oDone = {2{state == ST_VERIFY}} & gnt;
    assign oErr  = (state == ST_VERIFY) & (iQ != exp_q(cmd, q_prev));

endmodule

// File: tb/tb_jk_cmd_sched.sv
// Directed plus randomized bench for jk_cmd_sched with a JK cell
// model and a transaction-level reference for grants and results.
module tb_jk_cmd_sched;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] iReq = 2'b00;
    logic [1:0] iCmd0 = 2'b00;
    logic [1:0] iCmd1 = 2'b00;
    logic       oJ, oK, oTick, oErr, oBusy;
    logic [1:0] oGnt, oDone;

    logic q = 1'b0;
    logic q_load = 1'b0;
    logic q_val = 1'b0;
    logic ign = 1'b0;
    int   ph = 0;
    logic rr_m = 1'b0;
    int   passed = 0;
    int   total = 0;

    jk_cmd_sched #(.OLD_HZ(10), .NEW_HZ(1)) dut (
        .iClk  (clk),
        .iReset(rst),
        .iReq  (iReq),
        .iCmd0 (iCmd0),
        .iCmd1 (iCmd1),
        .iQ    (q),
        .oJ    (oJ),
        .oK    (oK),
        .oTick (oTick),
        .oGnt  (oGnt),
        .oDone (oDone),
        .oErr  (oErr),
        .oBusy (oBusy)
    );

    always #5 clk = ~clk;

    // Divider phase: restarts at 0 on reset, ticks at DIV-1
    always @(posedge clk) begin
        if (!rst) ph <= 0;
        else ph <= (ph + 1) % DIV;
    end

    // JK cell: samples J/K on tick cycles unless told to ignore them
    always @(posedge clk) begin
        if (q_load) q <= q_val;
        else if (oTick && !ign) begin
            case ({oJ, oK})
                2'b01: q <= 1'b0;
                2'b10: q <= 1'b1;
                2'b11: q <= ~q;
                default: q <= q;
            endcase
        end
    end

    function automatic logic jk_ref(input logic [1:0] c, input logic qp);
        if (c == 2'b00) return qp;
        if (c == 2'b01) return 1'b0;
        if (c == 2'b10) return 1'b1;
        return ~qp;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic setq(input logic v);
        iReq = 2'b00;
        q_val = v;
        q_load = 1'b1;
        @(negedge clk);
        q_load = 1'b0;
    endtask

    // Called at a negedge in IDLE with request inputs already driven
    task automatic serve(input string tag, input bit mid);
        logic [1:0] w, c;
        logic qp, qe;
        int n, k, tick_at;
        bit jk_ok, tk_ok;
        w = (iReq == 2'b11) ? (rr_m ? 2'b10 : 2'b01) : iReq;
        c = w[1] ? iCmd1 : iCmd0;
        qp = q;
        n = 0;
        @(negedge clk);
        while (oGnt == 2'b00 && n < 4) begin
            qp = q;
            @(negedge clk);
            n++;
        end
        chk({tag, "_gnt"}, {14'd0, oGnt}, {14'd0, w});
        chk({tag, "_gnt_lat"}, 16'(n), 16'd0);
        if (mid) begin
            iCmd0 = 2'b01;
            iReq = 2'b00;
        end
        tick_at = -1;
        jk_ok = 1'b1;
        tk_ok = 1'b1;
        k = 0;
        while (oDone == 2'b00 && k < DIV + 3) begin
            if (tick_at < 0 && ph == DIV - 1) tick_at = k;
            if (oTick !== (ph == DIV - 1)) tk_ok = 1'b0;
            if ({oJ, oK} !== c || oBusy !== 1'b1 || oGnt !== w) jk_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        qe = jk_ref(c, qp);
        chk({tag, "_done"}, {14'd0, oDone}, {14'd0, w});
        chk({tag, "_done_lat"}, 16'(k), 16'(tick_at + 1));
        chk({tag, "_apply"}, {15'd0, jk_ok}, 16'd1);
        chk({tag, "_tick"}, {15'd0, tk_ok}, 16'd1);
        chk({tag, "_verify"}, {11'd0, oJ, oK, oGnt, oBusy},
            {11'd0, 2'b00, w, 1'b1});
        chk({tag, "_err"}, {15'd0, oErr}, {15'd0, ign && (qp != qe)});
        if (!ign) chk({tag, "_q"}, {15'd0, q}, {15'd0, qe});
        rr_m = w[0];
        @(negedge clk);
        chk({tag, "_idle"}, {9'd0, oGnt, oDone, oBusy, oErr, oJ, oK}, 16'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit bad;
        // Reset held low with both requesting
        iReq = 2'b11;
        iCmd0 = 2'b10;
        iCmd1 = 2'b11;
        bad = 1'b0;
        repeat (17) begin
            @(negedge clk);
            if ({oJ, oK, oTick, oGnt, oDone, oErr, oBusy} !== 9'd0) bad = 1'b1;
        end
        chk("reset_outputs", {15'd0, bad}, 16'd0);
        rst = 1'b1;
        rr_m = 1'b0;
        serve("rst_release", 1'b0);

        // Cell ignores J/K: reset command on Q=1 leaves Q high
        setq(1'b1);
        ign = 1'b1;
        iCmd1 = 2'b01;
        iReq = 2'b10;
        serve("ignore_err", 1'b0);
        ign = 1'b0;

        // Both requesting, toggles, alternating grants
        setq(1'b0);
        iCmd0 = 2'b11;
        iCmd1 = 2'b11;
        iReq = 2'b11;
        serve("rr_a", 1'b0);
        serve("rr_b", 1'b0);
        serve("rr_c", 1'b0);

        // Single requester set
        setq(1'b0);
        iCmd0 = 2'b10;
        iReq = 2'b01;
        serve("set0", 1'b0);

        // Command and request change after grant
        setq(1'b0);
        iCmd0 = 2'b10;
        iReq = 2'b01;
        serve("mid_change", 1'b1);
        chk("mid_change_q", {15'd0, q}, 16'd1);

        // Reset during APPLY drops the operation
        setq(1'b0);
        k = 0;
        while (ph != 2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        iCmd0 = 2'b10;
        iReq = 2'b01;
        @(negedge clk);
        chk("rstmid_gnt", {14'd0, oGnt}, 16'd1);
        rst = 1'b0;
        iReq = 2'b00;
        @(negedge clk);
        chk("rstmid_outs", {9'd0, oJ, oK, oGnt, oDone, oBusy, oErr},
            16'd0);
        rst = 1'b1;
        rr_m = 1'b0;
        k = 0;
        bad = 1'b0;
        while (oTick !== 1'b1 && k < 20) begin
            if (oDone !== 2'b00) bad = 1'b1;
            @(negedge clk);
            k++;
        end
        chk("rstmid_first_tick", 16'(k), 16'(DIV - 1));
        chk("rstmid_no_done", {15'd0, bad}, 16'd0);
        chk("rstmid_q", {15'd0, q}, 16'd0);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            setq(1'($urandom_range(0, 1)));
            ign = ($urandom_range(0, 3) == 0);
            iCmd0 = 2'($urandom_range(0, 3));
            iCmd1 = 2'($urandom_range(0, 3));
            iReq = 2'($urandom_range(1, 3));
            serve("rand", 1'b0);
            ign = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
